// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver with majority vote feeding a show-ahead FIFO
module uart_rx_fifo #(
  parameter int FCLK   = 16_000_000,
  parameter int BAUDS  = 115200,
  parameter int WDATA  = 8,
  parameter int PARITY = 0,
  parameter int WSTOP  = 1,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RXD,
  output logic [WDATA-1:0]         DOUT,
  output logic                     PERR,
  output logic                     FERR,
  output logic                     VALID,
  input  logic                     READY,
  output logic                     OVR,
  input  logic                     CLR,
  output logic                     BRK,
  output logic [$clog2(DEPTH):0]   COUNT
);
  localparam int DIV = FCLK / (BAUDS * 16);
  localparam int CNW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int W   = WDATA + 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAITHI} state_t;
  state_t st, nxt;
  logic s1, rxs;
  logic [CNW-1:0] cnt;
  logic [3:0] phase, bitn;
  logic m0, m1, pbit, fe, sz;
  logic [WDATA-1:0] sh;
  logic tick, dec, eob, maj, push, pop, full, wr, fe_n, perr_n, brk_n;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign tick   = cnt == '0;
  assign dec    = tick && phase == 4'd9;
  assign eob    = tick && phase == 4'd15;
  assign maj    = (m0 & m1) | (m0 & rxs) | (m1 & rxs);
  assign fe_n   = fe | ~maj;
  assign perr_n = PARITY == 0 ? 1'b0 : ((^sh ^ pbit) != (PARITY == 1));
  assign brk_n  = push && sh == '0 && (PARITY == 0 || !pbit) && sz && !maj;
  assign VALID  = COUNT != '0;
  assign full   = COUNT == CW'(DEPTH);
  assign pop    = VALID & READY;
  assign wr     = push & (~full | pop);
  assign {DOUT, PERR, FERR} = mem[rp];
  // two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge CLK or posedge RST)
    if (RST) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {RXD, s1};
  // baud tick divider and bit phase; both held at origin while idle so phase 0 tracks the start edge
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt   <= CNW'(DIV - 1);
      phase <= '0;
    end else if (st == IDLE) begin
      cnt   <= CNW'(DIV - 1);
      phase <= '0;
    end else begin
      cnt   <= tick ? CNW'(DIV - 1) : cnt - CNW'(1);
      phase <= phase + {3'b000, tick};
    end
  // frame state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) st <= IDLE;
    else st <= nxt;
  // next-state and push decision; a failed stop bit parks in WAITHI until the line returns high
  always_comb begin
    nxt  = st;
    push = 1'b0;
    case (st)
      IDLE:    nxt = rxs ? IDLE : START;
      START:   nxt = (dec && maj) ? IDLE : eob ? DATA : START;
      DATA:    nxt = (eob && bitn == 4'(WDATA - 1)) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     nxt = eob ? STOP : PAR;
      STOP: begin
        push = dec && bitn == 4'(WSTOP - 1);
        nxt  = push ? (fe_n ? WAITHI : IDLE) : STOP;
      end
      WAITHI:  nxt = rxs ? IDLE : WAITHI;
      default: nxt = IDLE;
    endcase
  end
  // majority samples, data shifter, parity bit, stop-bit error and all-zero tracking
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      m0   <= 1'b1;
      m1   <= 1'b1;
      sh   <= '0;
      pbit <= 1'b0;
      fe   <= 1'b0;
      sz   <= 1'b1;
      bitn <= '0;
      BRK  <= 1'b0;
    end else begin
      m0   <= (tick && phase == 4'd7) ? rxs : m0;
      m1   <= (tick && phase == 4'd8) ? rxs : m1;
      sh   <= (st == DATA && dec) ? {maj, sh[WDATA-1:1]} : sh;
      pbit <= (st == PAR && dec) ? maj : pbit;
      fe   <= st == IDLE ? 1'b0 : (st == STOP && dec) ? fe_n : fe;
      sz   <= st == IDLE ? 1'b1 : (st == STOP && dec) ? sz & ~maj : sz;
      bitn <= st != nxt ? '0 : ((st == DATA || st == STOP) && eob) ? bitn + 4'd1 : bitn;
      BRK  <= brk_n;
    end
  // FIFO storage, pointers, occupancy and sticky overrun (set beats clear)
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      COUNT <= '0;
      OVR   <= 1'b0;
    end else begin
      if (wr) mem[wp] <= {sh, perr_n, fe_n};
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(pop);
      COUNT <= COUNT + CW'(wr) - CW'(pop);
      OVR   <= (push & full & ~pop) | (OVR & ~CLR);
    end
endmodule
